// File: rtl/clk_freq_meter.sv
// clk_freq_meter: measures period/high time of an asynchronous slow clock, classifies it
// against the divider rates and flags loss. Define CLK_FREQ_METER_DUTY_EN for high-time measurement.
module clk_freq_meter #(
  parameter int CNT_WIDTH    = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int PERIOD_1HZ   = 50_000_000,
  parameter int PERIOD_100HZ = 500_000,
  parameter int TOL          = 1_000,
  parameter int TIMEOUT      = 60_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 period_valid,
  output logic [1:0]           mode_det,
  output logic                 locked,
  output logic                 timeout
);
  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;
  localparam logic [CNT_WIDTH-1:0] L_P1  = CNT_WIDTH'(PERIOD_1HZ);
  localparam logic [CNT_WIDTH-1:0] L_P2  = CNT_WIDTH'(PERIOD_100HZ);
  localparam logic [CNT_WIDTH-1:0] L_TOL = CNT_WIDTH'(TOL);
  localparam logic [CNT_WIDTH-1:0] L_TMO = CNT_WIDTH'(TIMEOUT - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [0:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   w_lvl, w_rise, w_first, w_meas, w_tmo;
  logic [CNT_WIDTH-1:0]   w_p, w_d1, w_d2;
  logic [1:0]             w_mode;
  assign w_lvl   = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_lvl & ~r_hist;
  // clear outranks both a coinciding edge and a coinciding timeout
  assign w_first = r_state == S_WAIT && w_rise && !clear;
  assign w_meas  = r_state == S_MEAS && w_rise && !clear;
  assign w_tmo   = r_state == S_MEAS && !w_rise && !clear && r_cnt == L_TMO;
  assign w_p     = r_cnt + CNT_WIDTH'(1);
  assign w_d1    = w_p > L_P1 ? w_p - L_P1 : L_P1 - w_p;
  assign w_d2    = w_p > L_P2 ? w_p - L_P2 : L_P2 - w_p;
  assign w_mode  = w_d1 <= L_TOL ? 2'd1 : w_d2 <= L_TOL ? 2'd2 : 2'd3;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_hist <= w_lvl;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state      <= S_WAIT;
      r_cnt        <= '0;
      period       <= '0;
      mode_det     <= 2'd0;
      locked       <= 1'b0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= w_meas;
      timeout      <= w_tmo;
      if (clear || w_tmo) begin
        r_state  <= S_WAIT;
        r_cnt    <= '0;
        period   <= '0;
        mode_det <= 2'd0;
        locked   <= 1'b0;
      end else if (w_first) begin
        r_state <= S_MEAS;
        r_cnt   <= '0;
      end else if (w_meas) begin
        r_cnt    <= '0;
        period   <= w_p;
        mode_det <= w_mode;
        locked   <= w_mode != 2'd3 && w_mode == mode_det;
      end else if (r_state == S_MEAS) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
`ifdef CLK_FREQ_METER_DUTY_EN
  logic [CNT_WIDTH-1:0] r_hi_cnt;
  // starts at 1 on each rise because the rise cycle is itself high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hi_cnt  <= '0;
      high_time <= '0;
    end else if (clear || w_tmo) begin
      r_hi_cnt  <= '0;
      high_time <= '0;
    end else if (w_first || w_meas) begin
      r_hi_cnt <= CNT_WIDTH'(1);
      if (w_meas) high_time <= r_hi_cnt;
    end else if (r_state == S_MEAS && w_lvl) begin
      r_hi_cnt <= r_hi_cnt + CNT_WIDTH'(1);
    end
`else
  assign high_time = '0;
`endif
endmodule
